// File: rtl/bus_xfer_pkg.sv
// Shared types and defaults for the half-duplex bus transfer controller.
// Holds the FSM state encoding and a small state-decode helper.
package bus_xfer_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DRIVE = 3'd2,
        RECV  = 3'd3,
        TURN  = 3'd4
    } xfer_state_e;

    // The bus request is held from arbitration until the beat finishes or aborts.
    function automatic logic holds_bus(input xfer_state_e st);
        return (st == REQ) || (st == DRIVE) || (st == RECV);
    endfunction

endpackage

// File: rtl/bus_ack_timer.sv
// Saturating wait counter for the ack phase of a bus beat.
// expired flags the TIMEOUT-th enabled cycle so the FSM can abort on that edge.
module bus_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Count enabled cycles since the last clear, holding at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // cnt_r counts completed wait cycles, so the current cycle is number cnt_r+1.
    assign expired = enable && (cnt_r >= CNT_LAST);

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Master-side sequencer for a half-duplex tri-state bus: arbitrates, drives or
// receives one beat per command, and always inserts a one-cycle turnaround.
module bus_xfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             bus_req,
    input  logic             bus_gnt,
    input  logic             bus_ack,
    output logic             send_data,
    output logic             rcv_data,
    output logic [WIDTH-1:0] ckt_to_bus,
    input  logic [WIDTH-1:0] data_from_bus
);

    xfer_state_e      state_r;
    xfer_state_e      state_nxt_s;
    logic             cmd_write_r;
    logic [WIDTH-1:0] ckt_to_bus_r;
    logic [WIDTH-1:0] rsp_rdata_r;
    logic             bus_req_r;
    logic             send_data_r;
    logic             rcv_data_r;
    logic             rsp_valid_r;
    logic             rsp_err_r;
    logic             accept_s;
    logic             capture_s;
    logic             rsp_err_nxt_s;
    logic             tmr_clear_s;
    logic             tmr_en_s;
    logic             tmr_expired_s;

    bus_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear_s),
        .enable  (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // Next-state logic; an ack in the same cycle as timeout or grant loss still completes the beat.
    always_comb begin
        state_nxt_s   = state_r;
        accept_s      = 1'b0;
        capture_s     = 1'b0;
        rsp_err_nxt_s = 1'b0;
        tmr_clear_s   = 1'b0;
        tmr_en_s      = 1'b0;
        case (state_r)
            IDLE: begin
                tmr_clear_s = 1'b1;
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                tmr_clear_s = 1'b1;
                if (bus_gnt) begin
                    state_nxt_s = cmd_write_r ? DRIVE : RECV;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DRIVE, RECV: begin
                tmr_en_s = 1'b1;
                if (bus_ack) begin
                    state_nxt_s = TURN;
                    capture_s   = (state_r == RECV);
                end else if (!bus_gnt || tmr_expired_s) begin
                    state_nxt_s   = TURN;
                    rsp_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            TURN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and bus/response strobes, registered from the next state so reset releases the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            bus_req_r   <= 1'b0;
            send_data_r <= 1'b0;
            rcv_data_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_req_r   <= holds_bus(state_nxt_s);
            send_data_r <= (state_nxt_s == DRIVE);
            rcv_data_r  <= (state_nxt_s == RECV);
            rsp_valid_r <= (state_nxt_s == TURN);
            rsp_err_r   <= rsp_err_nxt_s;
        end
    end

    // Command latch and read-data capture; rsp_rdata only changes on a successful read beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_write_r  <= 1'b0;
            ckt_to_bus_r <= {WIDTH{1'b0}};
            rsp_rdata_r  <= {WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                cmd_write_r  <= cmd_write;
                ckt_to_bus_r <= cmd_wdata;
            end
            if (capture_s) begin
                rsp_rdata_r <= data_from_bus;
            end
        end
    end

    assign cmd_ready  = (state_r == IDLE);
    assign bus_req    = bus_req_r;
    assign send_data  = send_data_r;
    assign rcv_data   = rcv_data_r;
    assign ckt_to_bus = ckt_to_bus_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_rdata  = rsp_rdata_r;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: expected responses are queued at command issue
// and compared by a monitor when rsp_valid fires; bus-level timing is checked inline.
module tb_bus_xfer_ctrl;

    localparam int W  = 32;
    localparam int TO = 15;

    typedef struct packed {
        logic         err;
        logic [W-1:0] rdata;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [W-1:0] cmd_wdata;
    logic         rsp_valid;
    logic         rsp_err;
    logic [W-1:0] rsp_rdata;
    logic         bus_req;
    logic         bus_gnt;
    logic         bus_ack;
    logic         send_data;
    logic         rcv_data;
    logic [W-1:0] ckt_to_bus;
    logic [W-1:0] data_from_bus;

    int           errors = 0;
    int           checks = 0;
    int           pulses = 0;
    exp_t         exp_q[$];
    logic [W-1:0] rdata_model;
    int           acc;
    int           drives;
    int           n_rcv;
    int           pulses_before;
    logic         prev_send;

    bus_xfer_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .bus_req       (bus_req),
        .bus_gnt       (bus_gnt),
        .bus_ack       (bus_ack),
        .send_data     (send_data),
        .rcv_data      (rcv_data),
        .ckt_to_bus    (ckt_to_bus),
        .data_from_bus (data_from_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard and bus exclusivity monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("send_rcv_excl", 32'(send_data & rcv_data), 32'd0);
            if (rsp_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = 32'h0;
        bus_gnt = 1'b0; bus_ack = 1'b0; data_from_bus = 32'h0;
        rdata_model = 32'h0;
        tick(); tick();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_send", 32'(send_data), 32'd0);
        chk("rst_rcv", 32'(rcv_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_ckt", ckt_to_bus, 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;

        // Write, ack on the second DRIVE cycle.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 32'hDEAD_BEEF;
        exp_q.push_back('{1'b0, rdata_model});
        tick();
        cmd_valid = 1'b0;
        chk("wr_req", 32'(bus_req), 32'd1);
        chk("wr_ready_low", 32'(cmd_ready), 32'd0);
        chk("wr_req_nosend", 32'(send_data), 32'd0);
        bus_gnt = 1'b1;
        tick();
        chk("wr_send1", 32'(send_data), 32'd1);
        chk("wr_word1", ckt_to_bus, 32'hDEAD_BEEF);
        tick();
        chk("wr_send2", 32'(send_data), 32'd1);
        chk("wr_word2", ckt_to_bus, 32'hDEAD_BEEF);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; bus_gnt = 1'b0;
        chk("wr_turn_send", 32'(send_data), 32'd0);
        chk("wr_turn_req", 32'(bus_req), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        chk("wr_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("wr_idle_ready", 32'(cmd_ready), 32'd1);

        // Read with grant delayed four cycles.
        cmd_valid = 1'b1; cmd_write = 1'b0;
        rdata_model = 32'h1234_5678;
        exp_q.push_back('{1'b0, rdata_model});
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rd_wait_req", 32'(bus_req), 32'd1);
            chk("rd_wait_rcv", 32'(rcv_data), 32'd0);
            tick();
        end
        bus_gnt = 1'b1;
        tick();
        chk("rd_rcv", 32'(rcv_data), 32'd1);
        chk("rd_nosend", 32'(send_data), 32'd0);
        data_from_bus = 32'h1234_5678; bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; bus_gnt = 1'b0; data_from_bus = 32'hCAFE_F00D;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_turn_rcv", 32'(rcv_data), 32'd0);
        tick();
        chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);

        // Read timeout: no ack, previous read data must survive.
        cmd_valid = 1'b1; cmd_write = 1'b0;
        exp_q.push_back('{1'b1, rdata_model});
        tick();
        cmd_valid = 1'b0; bus_gnt = 1'b1;
        tick();
        n_rcv = 0;
        for (int i = 0; i < 40; i++) begin
            if (!rcv_data) break;
            n_rcv++;
            tick();
        end
        chk("to_rcv_cycles", 32'(n_rcv), 32'(TO));
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rdata_hold", rsp_rdata, 32'h1234_5678);
        bus_gnt = 1'b0;
        tick();

        // Grant loss during the second DRIVE cycle.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 32'hAAAA_5555;
        exp_q.push_back('{1'b1, rdata_model});
        tick();
        cmd_valid = 1'b0; bus_gnt = 1'b1;
        tick(); tick();
        chk("gl_send2", 32'(send_data), 32'd1);
        bus_gnt = 1'b0;
        tick();
        chk("gl_turn_send", 32'(send_data), 32'd0);
        chk("gl_rsp_err", 32'(rsp_err), 32'd1);
        tick();

        // Ack together with grant drop completes successfully.
        cmd_valid = 1'b1; cmd_write = 1'b0;
        rdata_model = 32'h0BAD_C0DE;
        exp_q.push_back('{1'b0, rdata_model});
        tick();
        cmd_valid = 1'b0; bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_ack = 1'b1; data_from_bus = 32'h0BAD_C0DE;
        tick();
        bus_ack = 1'b0;
        chk("ackgl_rsp_err", 32'(rsp_err), 32'd0);
        chk("ackgl_rdata", rsp_rdata, 32'h0BAD_C0DE);
        tick();

        // Back-to-back writes with cmd_valid, grant and ack held high.
        pulses_before = pulses;
        acc = 0; drives = 0; prev_send = 1'b0;
        cmd_write = 1'b1; cmd_wdata = 32'h1111_1111; cmd_valid = 1'b1;
        bus_gnt = 1'b1; bus_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (cmd_valid && cmd_ready) begin
                acc++;
                exp_q.push_back('{1'b0, rdata_model});
            end
            tick();
            if (acc >= 2) cmd_valid = 1'b0;
            cmd_wdata = 32'h2222_2222;
            if (send_data && !prev_send) drives++;
            if (send_data) chk("b2b_word", ckt_to_bus, (drives == 1) ? 32'h1111_1111 : 32'h2222_2222);
            chk("b2b_gap", 32'(send_data & prev_send), 32'd0);
            prev_send = send_data;
        end
        bus_gnt = 1'b0; bus_ack = 1'b0;
        chk("b2b_drives", 32'(drives), 32'd2);
        chk("b2b_pulses", 32'(pulses - pulses_before), 32'd2);

        // Asynchronous reset in the middle of a DRIVE cycle.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 32'h5A5A_A5A5;
        tick();
        cmd_valid = 1'b0; bus_gnt = 1'b1;
        tick();
        chk("ar_send_before", 32'(send_data), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_send", 32'(send_data), 32'd0);
        chk("ar_req", 32'(bus_req), 32'd0);
        chk("ar_rcv", 32'(rcv_data), 32'd0);
        chk("ar_ready", 32'(cmd_ready), 32'd1);
        chk("ar_rdata", rsp_rdata, 32'h0);
        tick();
        rst = 1'b0; bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
